// File: rtl/pipe_dmem_be.sv
// Single-port MEM-stage data memory with byte/half/word lanes, one-cycle extended
// load return, misalignment flagging and a post-reset zero-fill sequencer.
module pipe_dmem_be #(
  parameter int unsigned AW        = 5,
  parameter int unsigned ZERO_INIT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_datain,
  output logic        o_ready,
  output logic [31:0] o_dataout,
  output logic        o_dvalid,
  output logic        o_misalign,
  output logic        o_init_done
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t         r_state;
  logic [AW-1:0]  r_cnt;
  logic           r_ready;
  logic           r_dvalid;
  logic           r_misalign;
  logic [31:0]    r_dataout;
  logic [31:0]    r_mem [0:DEPTH-1];

  logic [AW-1:0]  w_idx;
  logic [1:0]     w_off;
  logic           w_accept;
  logic           w_legal;
  logic           w_store;
  logic           w_load;
  logic           w_init_wr;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata;
  logic [31:0]    w_word;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_ext;
  logic           w_unused_addr;

  assign w_idx         = i_addr[AW+1:2];
  assign w_off         = i_addr[1:0];
  assign w_unused_addr = &{1'b0, i_addr[31:AW+2]};
  assign w_accept      = i_req & r_ready;
  assign w_store       = w_accept & i_we & w_legal;
  assign w_load        = w_accept & ~i_we;
  // Held-in-reset INIT state must not keep scribbling word 0.
  assign w_init_wr     = (r_state == S_INIT) & ~i_rst;

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = i_datain;
    case (i_size)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{i_datain[7:0]}};
      end
      2'b01: begin
        w_legal = ~w_off[0];
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_datain[15:0]}};
      end
      2'b10: begin
        w_legal = (w_off == 2'b00);
        w_be    = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
      end
    endcase
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ext = '0;
    case (i_size)
      2'b00:   w_ext = i_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = i_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   w_ext = w_word;
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if (ZERO_INIT != 0) r_state <= S_INIT;
      else                r_state <= S_RUN;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_dvalid   <= 1'b0;
      r_misalign <= 1'b0;
      r_dataout  <= '0;
    end else begin
      r_dvalid   <= w_load;
      r_misalign <= w_accept & ~w_legal;
      if (w_load) r_dataout <= w_legal ? w_ext : '0;
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  // Array has no reset; it is cleared only by the INIT walk.
  always_ff @(posedge i_clk) begin
    if (w_init_wr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_init_done = r_ready;
  assign o_dvalid    = r_dvalid;
  assign o_misalign  = r_misalign;
  assign o_dataout   = r_dataout;

endmodule

// File: doc/pipe_dmem_be.md
Name: pipe_dmem_be

Overview:
Parametrised single-port pipeline data memory with byte/halfword/word access, replacing the fixed 32x32 word-only data RAM in the MEM stage. Requests are captured on the rising edge; load data is returned one cycle later, already sign- or zero-extended. Misaligned accesses are flagged. A post-reset init sequencer zero-fills the array before the first request is accepted.

Parameters:
AW, 5, word-address width; depth = 2**AW words of 32 bits
ZERO_INIT, 1, 1 = run zero-fill sequencer after reset; 0 = skip it (contents undefined, ready immediately)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
req  in  1  request valid
we   in  1  1 = store, 0 = load (qualified by req)
size  in  2  00 byte, 01 half, 10 word, 11 illegal
uns  in  1  load extension: 1 = zero-extend, 0 = sign-extend
addr  in  32  byte address; word index = addr[AW+1:2]; addr[31:AW+2] ignored (aliases)
datain  in  32  store data, right-justified
ready  out  1  1 = request can be accepted this cycle
dataout  out  32  extended load data
dvalid  out  1  one-cycle pulse: dataout valid for the load accepted previous cycle
misalign  out  1  one-cycle pulse, cycle after an illegal/misaligned request accepted
init_done  out  1  high once the zero-fill is complete; stays high until rst

Behaviour:
- Reset (async, any time, incl. mid-init or with a load in flight): ready=0, dvalid=0, misalign=0, dataout=0, init_done=0, in-flight load discarded. Array contents are not reset by rst itself.
- States: INIT, RUN. Leaving reset: if ZERO_INIT=1 enter INIT with counter=0; else go straight to RUN with init_done=1.
- INIT: each cycle writes 0 to word[counter], counter+1; after word 2**AW-1 is written, next state RUN, init_done=1. INIT takes exactly 2**AW cycles. ready=0 throughout; req ignored.
- RUN: ready=1 every cycle (no back-pressure). Accept = req & ready.
- Alignment: byte always legal; half legal iff addr[0]=0; word legal iff addr[1:0]=00; size=11 always illegal.
- Illegal accept: no array write; the next cycle misalign=1 and, if a load, dvalid=1 with dataout=0.
- Store (legal): written at the accept edge. Byte lanes: byte -> lane addr[1:0], data datain[7:0]; half -> lanes {addr[1],0}+1..{addr[1],0}, data datain[15:0]; word -> all lanes. Unselected lanes unchanged. Stores produce no dvalid.
- Load (legal): word index, addr[1:0], size, uns registered at the accept edge; the next cycle dvalid=1 and dataout = selected byte/half/word, extended per uns (word ignores uns). Latency exactly 1 cycle; back-to-back loads give back-to-back dvalid.
- dataout holds its last value when dvalid=0; only loads update it.
- Store then load to the same word in the next cycle returns the stored data (no stale read). Only one request per cycle (single port), so there is no same-cycle read/write conflict.
- Address wrap: addresses differing only in addr[31:AW+2] hit the same word.

Test Plan:
- Reset, AW=5, ZERO_INIT=1: ready=0 for exactly 32 cycles, then ready=1 and init_done=1; load addr 0x7C -> dataout=0x00000000, dvalid one cycle later.
- sw 0x11223344 @0x08; lb @0x0B -> 0x00000011; lb @0x08 -> 0x00000044; lh @0x0A -> 0x00001122; lw @0x08 -> 0x11223344.
- sb 0xA5 @0x11 over zero word; lb @0x11 (uns=0) -> 0xFFFFFFA5; lbu -> 0x000000A5; lw @0x10 -> 0x0000A500.
- lh @0x02 (legal) vs lh @0x03 and lw @0x06: misaligned -> misalign=1, dvalid=1, dataout=0; sw @0x05 -> misalign=1 and word 1 unchanged on re-read.
- sw 0xDEADBEEF @0x00 then lw @0x80 (AW=5 alias) on the next cycle -> 0xDEADBEEF; back-to-back loads each produce a one-cycle dvalid in consecutive cycles.
- Assert rst with a load in flight and again mid-INIT (counter=10): dvalid stays 0; INIT restarts from word 0 and lasts a full 32 cycles.
